// File: rtl/debouncer_botones.sv
// debouncer_botones: per-channel two-flop synchronizer plus stability FSM producing a debounced level and a one-cycle press pulse.
module debouncer_botones #(
    parameter int CANT_BOTONES   = 4,
    parameter int CICLOS_ESTABLE = 1000000,
    parameter int ANCHO_CONTADOR = 20
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [CANT_BOTONES-1:0] i_botones,
    output logic [CANT_BOTONES-1:0] o_botones_nivel,
    output logic [CANT_BOTONES-1:0] o_botones_pulso
);
    typedef enum logic [1:0] {BAJO, ESPERA_ALTO, ALTO, ESPERA_BAJO} estado_t;
    localparam logic [ANCHO_CONTADOR-1:0] LIMITE = ANCHO_CONTADOR'(CICLOS_ESTABLE - 1);
    logic [CANT_BOTONES-1:0] sync1_q, sync2_q;
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_botones;
            sync2_q <= sync1_q;
        end
    end
    genvar g;
    generate
        for (g = 0; g < CANT_BOTONES; g++) begin : g_canal
            estado_t                   estado_q, estado_d;
            logic [ANCHO_CONTADOR-1:0] cnt_q, cnt_d;
            logic                      nivel_q, nivel_d, pulso_q, pulso_d;
            logic                      s;
            assign s = sync2_q[g];
            always_comb begin
                estado_d = estado_q;
                cnt_d    = cnt_q;
                pulso_d  = 1'b0;
                case (estado_q)
                    BAJO: if (s) begin
                        estado_d = ESPERA_ALTO;
                        cnt_d    = '0;
                    end
                    ESPERA_ALTO: if (!s) estado_d = BAJO;
                        else if (cnt_q == LIMITE) begin
                            estado_d = ALTO;
                            pulso_d  = 1'b1;
                        end else cnt_d = cnt_q + 1'b1;
                    ALTO: if (!s) begin
                        estado_d = ESPERA_BAJO;
                        cnt_d    = '0;
                    end
                    ESPERA_BAJO: if (s) estado_d = ALTO;
                        else if (cnt_q == LIMITE) estado_d = BAJO;
                        else cnt_d = cnt_q + 1'b1;
                    default: estado_d = BAJO;
                endcase
                nivel_d = (estado_d == ALTO) || (estado_d == ESPERA_BAJO);
            end
            always_ff @(posedge i_clock) begin
                if (!i_reset) begin
                    estado_q <= BAJO;
                    cnt_q    <= '0;
                    nivel_q  <= 1'b0;
                    pulso_q  <= 1'b0;
                end else begin
                    estado_q <= estado_d;
                    cnt_q    <= cnt_d;
                    nivel_q  <= nivel_d;
                    pulso_q  <= pulso_d;
                end
            end
            assign o_botones_nivel[g] = nivel_q;
            assign o_botones_pulso[g] = pulso_q;
        end
    endgenerate
endmodule

// File: tb/tb_debouncer_botones.sv
// tb_debouncer_botones: directed scenario tasks with hand-computed expectations, CICLOS_ESTABLE=4.
module tb_debouncer_botones;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] botones;
    logic [3:0] nivel, pulso;
    int         n_vec = 0;
    int         n_err = 0;

    debouncer_botones #(.CANT_BOTONES(4), .CICLOS_ESTABLE(4), .ANCHO_CONTADOR(3)) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_botones(botones),
        .o_botones_nivel(nivel),
        .o_botones_pulso(pulso)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        botones = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (nivel !== 4'b0000 || pulso !== 4'b0000) begin
                n_err++;
                $display("FAIL reset: nivel=%b pulso=%b want 0000/0000", nivel, pulso);
            end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_clean_press();
        botones = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_vec++;
            if (pulso !== (k == 7 ? 4'b0001 : 4'b0000) || nivel !== (k >= 7 ? 4'b0001 : 4'b0000)) begin
                n_err++;
                $display("FAIL clean_press edge %0d: nivel=%b pulso=%b", k, nivel, pulso);
            end
        end
    endtask

    task automatic test_release_glitch();
        botones = 4'b0000;
        step();
        step();
        botones = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (pulso !== 4'b0000 || nivel !== 4'b0001) begin
                n_err++;
                $display("FAIL release_glitch cycle %0d: nivel=%b pulso=%b want 0001/0000", k, nivel, pulso);
            end
        end
    endtask

    task automatic test_release_and_repress();
        botones = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (pulso !== 4'b0000 || nivel !== (k < 7 ? 4'b0001 : 4'b0000)) begin
                n_err++;
                $display("FAIL release edge %0d: nivel=%b pulso=%b", k, nivel, pulso);
            end
        end
        botones = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (pulso !== (k == 7 ? 4'b0001 : 4'b0000) || nivel !== (k >= 7 ? 4'b0001 : 4'b0000)) begin
                n_err++;
                $display("FAIL repress edge %0d: nivel=%b pulso=%b", k, nivel, pulso);
            end
        end
        botones = 4'b0000;
        repeat (10) step();
        n_vec++;
        if (nivel !== 4'b0000) begin
            n_err++;
            $display("FAIL repress_release: nivel=%b want 0000", nivel);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] patron = 8'b0000_0101;
        for (int k = 0; k < 16; k++) begin
            botones = {3'b000, patron[k % 8]};
            step();
            n_vec++;
            if (pulso !== 4'b0000 || nivel !== 4'b0000) begin
                n_err++;
                $display("FAIL bounce cycle %0d: nivel=%b pulso=%b want 0000/0000", k, nivel, pulso);
            end
        end
    endtask

    task automatic test_simultaneous();
        botones = 4'b1010;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (pulso !== (k == 7 ? 4'b1010 : 4'b0000) || nivel !== (k >= 7 ? 4'b1010 : 4'b0000)) begin
                n_err++;
                $display("FAIL simultaneous edge %0d: nivel=%b pulso=%b", k, nivel, pulso);
            end
        end
        botones = 4'b0000;
        repeat (10) step();
    endtask

    task automatic test_reset_mid_count();
        botones = 4'b0001;
        repeat (5) step();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (pulso !== 4'b0000 || nivel !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_mid cycle %0d: nivel=%b pulso=%b want 0000/0000", k, nivel, pulso);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (pulso !== (k == 7 ? 4'b0001 : 4'b0000) || nivel !== (k >= 7 ? 4'b0001 : 4'b0000)) begin
                n_err++;
                $display("FAIL reset_release edge %0d: nivel=%b pulso=%b", k, nivel, pulso);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        botones = 4'b0000;
        test_reset();
        test_bounce();
        test_clean_press();
        test_release_glitch();
        test_release_and_repress();
        test_simultaneous();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
